// File: rtl/keypad_matrix_scanner.sv
// 4x4 active-low keypad scanner: one column driven low per scan tick, full-matrix
// snapshot debounced over several frames, one-cycle strobe on a single new key press.
module keypad_matrix_scanner #(
    parameter int CLK_DIV         = 24000,
    parameter int DEBOUNCE_FRAMES = 5
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int             DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [3:0]     DEB_MAX  = 4'(DEBOUNCE_FRAMES);

    typedef enum logic [0:0] {
        SCAN = 1'b0,
        EVAL = 1'b1
    } state_t;

    logic [3:0]       row_meta_r;
    logic [3:0]       row_sync_r;
    logic [DIV_W-1:0] div_r;
    logic [1:0]       idx_r;
    logic [3:0]       col_n_r;
    logic [15:0]      snap_r;
    logic [15:0]      prev_r;
    logic [15:0]      deb_r;
    logic [15:0]      old_r;
    logic [3:0]       cnt_r;
    logic [3:0]       key_code_r;
    logic             key_valid_r;
    logic             key_held_r;
    state_t           state_r;
    state_t           state_nxt_s;
    logic             eval_s;
    logic             tick_s;
    logic [1:0]       idx_nxt_s;
    logic [3:0]       cnt_nxt_s;
    logic [15:0]      deb_nxt_s;
    logic [15:0]      old_nxt_s;
    logic             key_event_s;

    function automatic logic is_onehot(input logic [15:0] v);
        logic [4:0] n;
        n = 5'd0;
        for (int i = 0; i < 16; i++) begin
            n = n + {4'd0, v[i]};
        end
        return (n == 5'd1);
    endfunction

    function automatic logic [3:0] onehot_index(input logic [15:0] v);
        logic [3:0] k;
        k = 4'd0;
        for (int i = 0; i < 16; i++) begin
            k = v[i] ? 4'(i) : k;
        end
        return k;
    endfunction

    // Two-flop synchronizer for the asynchronous row inputs; idle rows read released
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_meta_r <= 4'hF;
            row_sync_r <= 4'hF;
        end else begin
            row_meta_r <= row_n;
            row_sync_r <= row_meta_r;
        end
    end

    // Scan tick and next column index
    always_comb begin
        tick_s    = (div_r == DIV_LAST);
        idx_nxt_s = idx_r + 2'd1;
    end

    // Free-running divider, column drive and per-column row capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_r   <= '0;
            idx_r   <= 2'd0;
            col_n_r <= 4'b1110;
            snap_r  <= 16'd0;
        end else if (tick_s) begin
            div_r                     <= '0;
            snap_r[{idx_r, 2'b00} +: 4] <= ~row_sync_r;
            idx_r                     <= idx_nxt_s;
            col_n_r                   <= ~(4'b0001 << idx_nxt_s);
        end else begin
            div_r <= div_r + DIV_W'(1);
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= SCAN;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: the tick that samples column 3 closes a frame
    always_comb begin
        state_nxt_s = SCAN;
        case (state_r)
            SCAN:    state_nxt_s = (tick_s && (idx_r == 2'd3)) ? EVAL : SCAN;
            EVAL:    state_nxt_s = SCAN;
            default: state_nxt_s = SCAN;
        endcase
    end

    // FSM outputs
    always_comb begin
        eval_s = (state_r == EVAL);
    end

    // Debounce arithmetic; a press event needs an empty previous stable state
    always_comb begin
        cnt_nxt_s = cnt_r;
        deb_nxt_s = deb_r;
        old_nxt_s = old_r;
        if (eval_s) begin
            if (snap_r == prev_r) begin
                cnt_nxt_s = (cnt_r >= DEB_MAX) ? DEB_MAX : (cnt_r + 4'd1);
            end else begin
                cnt_nxt_s = 4'd1;
            end
            if (cnt_nxt_s == DEB_MAX) begin
                deb_nxt_s = snap_r;
                old_nxt_s = deb_r;
            end else begin
                deb_nxt_s = deb_r;
                old_nxt_s = old_r;
            end
        end else begin
            cnt_nxt_s = cnt_r;
        end
        key_event_s = eval_s && (deb_nxt_s != deb_r) && (old_nxt_s == 16'd0)
                      && is_onehot(deb_nxt_s);
    end

    // Debounce state registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r  <= 4'd0;
            prev_r <= 16'd0;
            deb_r  <= 16'd0;
            old_r  <= 16'd0;
        end else begin
            cnt_r <= cnt_nxt_s;
            deb_r <= deb_nxt_s;
            old_r <= old_nxt_s;
            if (eval_s) begin
                prev_r <= snap_r;
            end
        end
    end

    // Registered key outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            key_code_r  <= 4'd0;
            key_valid_r <= 1'b0;
            key_held_r  <= 1'b0;
        end else begin
            key_valid_r <= key_event_s;
            key_held_r  <= |deb_nxt_s;
            if (key_event_s) begin
                key_code_r <= onehot_index(deb_nxt_s);
            end
        end
    end

    assign col_n     = col_n_r;
    assign key_code  = key_code_r;
    assign key_valid = key_valid_r;
    assign key_held  = key_held_r;

endmodule

// File: tb/tb_keypad_matrix_scanner.sv
// Scoreboard bench for keypad_matrix_scanner (CLK_DIV=4, DEBOUNCE_FRAMES=2, 16-cycle frame):
// a key-matrix model drives row_n; expected strobes are queued, a monitor pops and compares.
module tb_keypad_matrix_scanner;

    localparam int FRAME = 16;

    typedef struct {
        logic [3:0] code;
        int         min_cyc;
        int         max_cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_n;
    logic [3:0]  col_n;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_held;
    logic [15:0] pressed;
    logic        prev_valid;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;
    int          c0;
    exp_t        q[$];

    keypad_matrix_scanner #(.CLK_DIV(4), .DEBOUNCE_FRAMES(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .row_n     (row_n),
        .col_n     (col_n),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Key matrix: a pressed key pulls its row low while its column is driven low
    always_comb begin
        row_n = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                if (!col_n[c] && pressed[c*4+r]) row_n[r] = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every strobe must match the head of the expectation queue
    always @(negedge clk) begin
        if (rst === 1'b1) begin
            chk("col_one_low", 32'($countones(~col_n)), 32'd1);
            if (key_valid) begin
                chk("no_back_to_back", {31'd0, prev_valid}, 32'd0);
                chk("held_at_strobe", {31'd0, key_held}, 32'd1);
                if (q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got code %0d expected no strobe (cycle %0d)",
                             key_code, cyc);
                end else begin
                    chk("key_code", {28'd0, key_code}, {28'd0, q[0].code});
                    chk("strobe_window", {31'd0, (cyc >= q[0].min_cyc) && (cyc <= q[0].max_cyc)},
                        32'd1);
                    q.delete(0);
                end
            end
            prev_valid <= key_valid;
        end else begin
            prev_valid <= 1'b0;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst     = 1'b0;
        pressed = 16'd0;
        wait_cycles(3);
        chk("rst_col_n", {28'd0, col_n}, 32'hE);
        chk("rst_key_code", {28'd0, key_code}, 32'd0);
        chk("rst_key_valid", {31'd0, key_valid}, 32'd0);
        chk("rst_key_held", {31'd0, key_held}, 32'd0);
        rst = 1'b1;

        // Column rotation: column p/4 driven after p clock edges
        for (int p = 1; p <= 16; p++) begin
            logic [3:0] one;
            one = 4'b0001;
            @(negedge clk);
            chk("col_seq", {28'd0, col_n}, {28'd0, ~(one << ((p / 4) % 4))});
        end
        for (int f = 0; f < 3; f++) begin
            wait_cycles(FRAME);
            chk("idle_held", {31'd0, key_held}, 32'd0);
        end

        // Single key col2/row1, held 5 frames then released, then pressed again
        for (int rep = 0; rep < 2; rep++) begin
            c0 = cyc;
            q.push_back('{4'd9, c0, c0 + FRAME + 3 * FRAME + 2});
            pressed[9] = 1'b1;
            wait_cycles(3 * FRAME);
            chk("hold_held", {31'd0, key_held}, 32'd1);
            wait_cycles(2 * FRAME);
            pressed = 16'd0;
            wait_cycles(4 * FRAME);
            chk("release_held", {31'd0, key_held}, 32'd0);
            chk("hold_queue_empty", 32'(q.size()), 32'd0);
        end

        // Glitch shorter than a frame
        pressed[9] = 1'b1;
        wait_cycles(10);
        pressed = 16'd0;
        for (int i = 0; i < 4 * FRAME; i++) begin
            @(negedge clk);
            chk("glitch_held", {31'd0, key_held}, 32'd0);
        end

        // Two keys together, then down to one, then a lone new key
        pressed[0]  = 1'b1;
        pressed[15] = 1'b1;
        wait_cycles(4 * FRAME);
        chk("multi_held", {31'd0, key_held}, 32'd1);
        pressed[15] = 1'b0;
        wait_cycles(4 * FRAME);
        chk("multi_to_single_held", {31'd0, key_held}, 32'd1);
        pressed = 16'd0;
        wait_cycles(4 * FRAME);
        chk("multi_release_held", {31'd0, key_held}, 32'd0);
        c0 = cyc;
        q.push_back('{4'd15, c0, c0 + FRAME + 3 * FRAME + 2});
        pressed[15] = 1'b1;
        wait_cycles(4 * FRAME);
        chk("k15_held", {31'd0, key_held}, 32'd1);
        pressed = 16'd0;
        wait_cycles(4 * FRAME);
        chk("multi_queue_empty", 32'(q.size()), 32'd0);

        // Reset in the middle of debouncing key col1/row1
        pressed[5] = 1'b1;
        wait_cycles(20);
        @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst_col_n", {28'd0, col_n}, 32'hE);
        chk("midrst_key_code", {28'd0, key_code}, 32'd0);
        chk("midrst_key_valid", {31'd0, key_valid}, 32'd0);
        chk("midrst_key_held", {31'd0, key_held}, 32'd0);
        wait_cycles(3);
        rst = 1'b1;
        c0 = cyc;
        q.push_back('{4'd5, c0 + 2 * FRAME + 1, c0 + 2 * FRAME + 1});
        wait_cycles(4 * FRAME);
        chk("rst_rekey_held", {31'd0, key_held}, 32'd1);
        pressed = 16'd0;
        wait_cycles(4 * FRAME);
        chk("final_held", {31'd0, key_held}, 32'd0);
        chk("final_queue_empty", 32'(q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/keypad_matrix_scanner.md
# keypad_matrix_scanner

- Scans a 4×4 active-low key matrix on the washing-machine control panel by driving one column low at a time and sampling the four row inputs.
- Debounces the complete 16-key snapshot.
- Emits a one-cycle `key_valid` strobe with a 4-bit key code when exactly one key goes from released to pressed.
- Forms the input-side counterpart of the display digit scanner; shares the 24 MHz clock and the 1 ms scan tick rate.

## Interface
- `CLK_DIV`, default 24000: clk cycles per scan tick (1 ms at 24 MHz); legal ≥ 4.
- `DEBOUNCE_FRAMES`, default 5: number of consecutive identical full-matrix frames required before the debounced state updates; legal 1..15.
- `clk`, input, 1: system clock.
- `rst`, input, 1: reset, asynchronous, active-low.
- `row_n`, input, 4: matrix rows, active-low (external pull-ups); asynchronous to clk.
- `col_n`, output, 4: column drive, active-low, exactly one bit low at all times.
- `key_code`, output, 4: code of the last accepted key, = col*4 + row.
- `key_valid`, output, 1: one-cycle strobe; `key_code` is valid in the same cycle.
- `key_held`, output, 1: level, high while the debounced state shows any key pressed.

## Operation
- `row_n` passes through a 2-flop synchronizer (`row_s`) before any use.
- Divider counts 0..CLK_DIV-1. `tick` is high in the cycle where the count equals CLK_DIV-1, then the count wraps to 0.
- Column index `idx` (2 bits) resets to 0, so `col_n` = 4'b1110.
- On each tick edge, in one clock:
  - `snap[idx*4 + r]` <= ~`row_s[r]` for r = 0..3;
  - `idx` <= `idx` + 1, wrapping 3→0;
  - `col_n` <= ~(1 << new `idx`).
- State machine has two states:
  - SCAN: default. A tick with `idx` == 3 completes a frame; the next state is EVAL.
  - EVAL: lasts one cycle, then returns to SCAN.
- Actions in EVAL:
  - If `snap` == `prev`: `cnt` <= min(`cnt`+1, DEBOUNCE_FRAMES). Otherwise `cnt` <= 1.
  - `prev` <= `snap`.
  - If the new `cnt` == DEBOUNCE_FRAMES: `deb` <= `snap` and `old` <= `deb`. Otherwise `deb` is unchanged.
- Event rule, evaluated in the cycle after EVAL: if `deb` changed, `old` == 0, and `deb` has exactly one bit set, then `key_valid` = 1 and `key_code` = the index of that bit.
- No event is generated in these cases:
  - two or more keys become stable together;
  - the state changes from multiple keys to a single key;
  - a key is released.
- `key_held` = |`deb`, registered; it updates in the cycle after EVAL.
- A glitch shorter than one full frame never reaches `deb`.
- The divider and the column scan free-run regardless of key activity.

## Timing
- Reset values: `col_n`=4'b1110, `key_code`=0, `key_valid`=0, `key_held`=0. `idx`, divider, `snap`, `prev`, `deb`, `old` and `cnt` all reset to 0.
- Reset is asynchronous and may occur mid-frame or mid-EVAL. All state clears immediately, and the first tick comes CLK_DIV cycles after `rst` deasserts.
- Each column is driven for CLK_DIV cycles before its rows are sampled. This is far beyond the 2-cycle synchronizer delay plus matrix settling time.
- Frame period = 4·CLK_DIV cycles. EVAL occurs 1 cycle after the 4th tick. `key_valid` occurs 1 cycle after EVAL.
- Worst-case press-to-strobe latency = (DEBOUNCE_FRAMES+1)·4·CLK_DIV + 2 cycles.
- `key_valid` is never high for two consecutive cycles. Successive strobes are at least DEBOUNCE_FRAMES frames apart.
- The `cnt` saturation rule and the wrap of `idx` 3→0 are exercised on every frame.

## Test plan
Parameters for all scenarios: CLK_DIV=4, DEBOUNCE_FRAMES=2; frame = 16 cycles.
- Reset, no keys: `col_n` cycles 1110→1101→1011→0111, each for 4 cycles. `key_valid` never asserts and `key_held`=0 indefinitely.
- Hold column 2 / row 1 (`row_n[1]` low only while `col_n[2]`=0) for 5 frames: exactly one `key_valid`, with `key_code`=9 and `key_held`=1. It arrives within 3·16+2 cycles of the first sampled press.
- Press the key for 10 cycles only, less than one frame: no `key_valid`, `key_held` stays 0.
- Press col0/row0 and col3/row3 together: `key_held`=1 and no strobe. Release col3/row3 while holding col0/row0: still no strobe. Release all, then press col3/row3 alone: strobe with `key_code`=15.
- Hold a key, then release it: `key_held` falls to 0 after 2 stable frames, with no strobe on release. Re-press: a new strobe.
- Assert `rst` in the middle of debouncing a pressed key: all outputs return to reset values immediately. After release of reset the key is re-debounced from scratch, and the strobe comes 2 full frames after resumption.
